// File: rtl/ooo_reservation_station_pkg.sv
// Shared types and constants for the out-of-order reservation station.
package ooo_reservation_station_pkg;

  localparam int PREG_W = 32;  // physical register id width
  localparam int AREG_W = 32;  // architectural register id width
  localparam int ROB_W  = 32;  // ROB index width

  // Station select codes driven by dispatch
  localparam logic [1:0] RS_ALU = 2'd0;
  localparam logic [1:0] RS_MUL = 2'd1;
  localparam logic [1:0] RS_BR  = 2'd2;
  localparam logic [1:0] RS_MEM = 2'd3;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] ps1;
    logic              ps1_rdy;
    logic [PREG_W-1:0] ps2;
    logic              ps2_rdy;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_entry;
  } rs_entry_t;

endpackage

// File: rtl/ooo_reservation_station_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set
// and the index of the lowest set bit.
module ooo_reservation_station_prio_enc #(
  parameter int N   = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ooo_reservation_station.sv
// Reservation station: buffers dispatched micro-ops until both sources are
// ready, snoops the CDB for wakeups and issues one ready op per cycle.
module ooo_reservation_station
  import ooo_reservation_station_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter logic [1:0] RS_ID = RS_ALU
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rs_select,
  input  logic              dispatch_ps_ready1,
  input  logic              dispatch_ps_ready2,
  input  logic [PREG_W-1:0] ps1,
  input  logic [PREG_W-1:0] ps2,
  input  logic [AREG_W-1:0] rd,
  input  logic [PREG_W-1:0] pd,
  input  logic [ROB_W-1:0]  rob_entry,
  input  logic [PREG_W-1:0] cdb_ps_id,
  input  logic              fu_busy,
  output logic              regf_we,
  output logic              fu_ready,
  output rs_entry_t         issue_entry
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        entry_q [DEPTH];
  rs_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] rdy_vec;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             rdy_found;
  logic [IDX_W-1:0] rdy_idx;
  logic             cdb_valid;
  logic             dispatch_en;
  rs_entry_t        new_entry;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_vec
      assign free_vec[gi] = ~entry_q[gi].valid;
      assign rdy_vec[gi]  = entry_q[gi].valid & entry_q[gi].ps1_rdy & entry_q[gi].ps2_rdy;
    end
  endgenerate

  ooo_reservation_station_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_free_enc (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  ooo_reservation_station_prio_enc #(.N(DEPTH), .IDX_W(IDX_W)) u_rdy_enc (
    .req   (rdy_vec),
    .found (rdy_found),
    .idx   (rdy_idx)
  );

  assign cdb_valid   = (cdb_ps_id != '0);
  assign dispatch_en = (rs_select == RS_ID) && (pd != '0) && free_found;
  assign fu_ready    = rdy_found;
  assign regf_we     = rdy_found & ~fu_busy;

  // Incoming op, with the CDB bypass so a same-cycle wakeup is not lost
  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.ps1       = ps1;
    new_entry.ps1_rdy   = dispatch_ps_ready1 | (cdb_valid && (cdb_ps_id == ps1));
    new_entry.ps2       = ps2;
    new_entry.ps2_rdy   = dispatch_ps_ready2 | (cdb_valid && (cdb_ps_id == ps2));
    new_entry.rd        = rd;
    new_entry.pd        = pd;
    new_entry.rob_entry = rob_entry;
  end

  // Issue bus: fields of the selected entry, valid only while regf_we is high
  always_comb begin
    issue_entry = '0;
    if (regf_we) begin
      issue_entry = entry_q[rdy_idx];
    end
    issue_entry.valid = regf_we;
  end

  // Next state: wakeup, then issue free, then dispatch into the pre-edge free slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid && cdb_valid) begin
        if (entry_q[i].ps1 == cdb_ps_id) entry_d[i].ps1_rdy = 1'b1;
        if (entry_q[i].ps2 == cdb_ps_id) entry_d[i].ps2_rdy = 1'b1;
      end
    end
    if (regf_we) begin
      entry_d[rdy_idx].valid = 1'b0;
    end
    if (dispatch_en) begin
      entry_d[free_idx] = new_entry;
    end
  end

  // Entry storage; reset discards every entry immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: tb/tb_ooo_reservation_station.sv
// Self-checking bench for ooo_reservation_station: directed scenarios plus
// randomized traffic checked against a slot-level behavioural model.
module tb_ooo_reservation_station;
  import ooo_reservation_station_pkg::*;

  localparam int DEPTH = 8;

  logic              clk;
  logic              rst;
  logic [1:0]        rs_select;
  logic              dispatch_ps_ready1;
  logic              dispatch_ps_ready2;
  logic [PREG_W-1:0] ps1;
  logic [PREG_W-1:0] ps2;
  logic [AREG_W-1:0] rd;
  logic [PREG_W-1:0] pd;
  logic [ROB_W-1:0]  rob_entry;
  logic [PREG_W-1:0] cdb_ps_id;
  logic              fu_busy;
  logic              regf_we;
  logic              fu_ready;
  rs_entry_t         issue_entry;

  ooo_reservation_station #(.DEPTH(DEPTH), .RS_ID(RS_ALU)) dut (
    .clk                (clk),
    .rst                (rst),
    .rs_select          (rs_select),
    .dispatch_ps_ready1 (dispatch_ps_ready1),
    .dispatch_ps_ready2 (dispatch_ps_ready2),
    .ps1                (ps1),
    .ps2                (ps2),
    .rd                 (rd),
    .pd                 (pd),
    .rob_entry          (rob_entry),
    .cdb_ps_id          (cdb_ps_id),
    .fu_busy            (fu_busy),
    .regf_we            (regf_we),
    .fu_ready           (fu_ready),
    .issue_entry        (issue_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int we_pulses   = 0;

  // Reference model: one record per slot
  bit          m_valid [DEPTH];
  int unsigned m_ps1   [DEPTH];
  int unsigned m_ps2   [DEPTH];
  bit          m_r1    [DEPTH];
  bit          m_r2    [DEPTH];
  int unsigned m_rd    [DEPTH];
  int unsigned m_pd    [DEPTH];
  int unsigned m_rob   [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model
  task automatic step(input logic [1:0] sel, input bit r1, input bit r2,
                      input int unsigned p1, input int unsigned p2,
                      input int unsigned d_rd, input int unsigned d_pd,
                      input int unsigned d_rob, input int unsigned cdb, input bit busy);
    bit exp_fu;
    bit exp_we;
    int sel_i;
    int free_i;
    @(negedge clk);
    rs_select          = sel;
    dispatch_ps_ready1 = r1;
    dispatch_ps_ready2 = r2;
    ps1                = p1;
    ps2                = p2;
    rd                 = d_rd;
    pd                 = d_pd;
    rob_entry          = d_rob;
    cdb_ps_id          = cdb;
    fu_busy            = busy;
    #1;
    exp_fu = 0;
    sel_i  = -1;
    free_i = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_r1[i] && m_r2[i] && sel_i < 0) sel_i = i;
      if (!m_valid[i] && free_i < 0) free_i = i;
    end
    exp_fu = (sel_i >= 0);
    exp_we = exp_fu && !busy;
    chk("fu_ready", 32'(fu_ready), 32'(exp_fu));
    chk("regf_we", 32'(regf_we), 32'(exp_we));
    if (regf_we) we_pulses++;
    if (exp_we) begin
      $display("issue slot %0d pd=%0d rob=%0d", sel_i, m_pd[sel_i], m_rob[sel_i]);
      chk("issue_pd", issue_entry.pd, m_pd[sel_i]);
      chk("issue_rd", issue_entry.rd, m_rd[sel_i]);
      chk("issue_rob", issue_entry.rob_entry, m_rob[sel_i]);
    end
    // Wakeup of held entries
    if (cdb != 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i] && m_ps1[i] == cdb) m_r1[i] = 1;
        if (m_valid[i] && m_ps2[i] == cdb) m_r2[i] = 1;
      end
    end
    if (exp_we) m_valid[sel_i] = 0;
    if (sel == RS_ALU && d_pd != 0 && free_i >= 0) begin
      m_valid[free_i] = 1;
      m_ps1[free_i]   = p1;
      m_ps2[free_i]   = p2;
      m_r1[free_i]    = r1 || (cdb != 0 && cdb == p1);
      m_r2[free_i]    = r2 || (cdb != 0 && cdb == p2);
      m_rd[free_i]    = d_rd;
      m_pd[free_i]    = d_pd;
      m_rob[free_i]   = d_rob;
    end
  endtask

  task automatic idle(input int n, input bit busy);
    for (int k = 0; k < n; k++) step(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must drop without a clock
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk({tag, "_fu_ready"}, 32'(fu_ready), 32'd0);
    chk({tag, "_regf_we"}, 32'(regf_we), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    rs_select = '0; dispatch_ps_ready1 = 0; dispatch_ps_ready2 = 0;
    ps1 = '0; ps2 = '0; rd = '0; pd = '0; rob_entry = '0; cdb_ps_id = '0; fu_busy = 0;
    model_clear();
    #3;
    chk("reset_fu_ready", 32'(fu_ready), 32'd0);
    chk("reset_regf_we", 32'(regf_we), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Idle: nothing allocated
    idle(3, 0);

    // Dispatch with source 2 pending, then wake it from the CDB
    step(2'd0, 1, 0, 32, 33, 2, 45, 0, 38, 0);
    idle(1, 0);
    step(2'd0, 0, 0, 0, 0, 0, 0, 0, 33, 0);
    idle(2, 0);

    // Same dispatch with the wakeup on the CDB in the dispatch cycle
    step(2'd0, 1, 0, 32, 33, 2, 46, 1, 33, 0);
    idle(2, 0);

    // Two ready entries held by fu_busy, then released in index order
    step(2'd0, 1, 1, 5, 6, 3, 60, 2, 0, 1);
    step(2'd0, 1, 1, 7, 8, 4, 61, 3, 0, 1);
    idle(3, 1);
    idle(3, 0);

    // Source id 0 is never woken by a broadcast
    step(2'd0, 0, 1, 0, 9, 5, 70, 4, 0, 0);
    idle(2, 0);
    do_reset("midrst");

    // Fill every slot with unready ops, then one extra ready op that must drop
    for (int i = 0; i < DEPTH; i++) step(2'd0, 0, 0, 100 + i, 200 + i, i, 50 + i, i, 0, 0);
    step(2'd0, 1, 1, 1, 2, 9, 99, 9, 0, 0);
    we_pulses = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(2'd0, 0, 0, 0, 0, 0, 0, 0, 100 + i, 0);
      step(2'd0, 0, 0, 0, 0, 0, 0, 0, 200 + i, 0);
    end
    idle(3, 0);
    chk("fill_pulses", 32'(we_pulses), 32'(DEPTH));

    // Randomized traffic
    do_reset("rnd_rst");
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  s;
      int unsigned dpd;
      s   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      dpd = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 1000);
      step(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31), dpd,
           $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3) == 0);
    end
    do_reset("end_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ooo_reservation_station.md
# ooo_reservation_station

Holds dispatched micro-ops in an out-of-order core until both source physical registers are ready. It snoops the common data bus (CDB) for wakeups and issues one ready entry per cycle to its functional unit when that unit is not busy. The block sits between rename/dispatch and the functional unit. The ROB and the physical register file sit alongside it.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, ≥2).
- RS_ID, 2'd0, `rs_select` code that addresses this station.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low; clears all entries.
- rs_select  in  2  dispatch target code; this station accepts only when it equals RS_ID.
- dispatch_ps_ready1  in  1  source 1 is already ready at dispatch.
- dispatch_ps_ready2  in  1  source 2 is already ready at dispatch.
- ps1  in  32  source-1 physical register id.
- ps2  in  32  source-2 physical register id.
- rd  in  32  architectural destination register.
- pd  in  32  physical destination; 0 means no dispatch this cycle.
- rob_entry  in  32  ROB index of the op.
- cdb_ps_id  in  32  physical register broadcast on the CDB this cycle; 0 means no broadcast.
- fu_busy  in  1  FU cannot accept an op this cycle.
- regf_we  out  1  issue strobe; the selected entry is sent to register-file read / FU and freed this cycle.
- fu_ready  out  1  at least one valid entry has both sources ready.

## Operation
- Entry fields: valid, ps1, ps1_rdy, ps2, ps2_rdy, rd, pd, rob_entry.
- Dispatch condition: rs_select == RS_ID, pd != 0, and a free entry exists.
  - The op is written into the lowest-index free entry.
  - ps1_rdy = dispatch_ps_ready1 | (cdb_ps_id != 0 && cdb_ps_id == ps1); ps2_rdy is formed the same way from ps2.
- Dispatch while full is silently dropped. Dispatch must be throttled upstream with an occupancy credit: decrement on each accepted dispatch, increment on each regf_we.
- Wakeup: when cdb_ps_id != 0, every valid entry with psN == cdb_ps_id sets psN_rdy at the clock edge. Both sources may wake in the same cycle.
- Physical register 0 is a constant and is never a wakeup target. A source with psN == 0 counts as ready only if dispatch_psN_ready was set.
- fu_ready = OR over entries of (valid & ps1_rdy & ps2_rdy). It is computed from registered state only.
- regf_we = fu_ready & !fu_busy.
  - When regf_we is high, the lowest-index ready entry is selected.
  - Its valid bit clears at the edge.
  - Its fields are held on the internal issue bus for downstream latching.
- Simultaneous events:
  - Issue and dispatch in the same cycle: the issued slot is not reused that cycle; dispatch takes the lowest free slot as seen before the edge.
  - A wakeup arriving the same cycle as an entry's dispatch is captured via the dispatch bypass.
  - A wakeup for an entry that issues the same cycle is irrelevant.

## Timing
- Reset: all valid bits are 0, so fu_ready = 0 and regf_we = 0 immediately and asynchronously while rst is low. Ready bits clear too.
- An op dispatched with both sources ready raises fu_ready the cycle after the dispatch edge.
- A CDB wakeup at edge N raises fu_ready in cycle N+1; issue can occur on edge N+1.
- One issue per cycle maximum; issue completes in the same cycle as regf_we.
- fu_busy high holds all entries; fu_ready stays high and regf_we stays low.
- Reset mid-operation discards all entries with no issue.

## Structure
- Shared package: rs_entry_t struct, PREG_W, ROB_W, RS_ID encodings (ALU=0, MUL=1, BR=2, MEM=3).
- One natural sub-module: rs_prio_enc, a parameterised lowest-index priority encoder. It is used twice, for free-slot select and for ready-slot select.

## Test plan
- Reset: rst=0 -> fu_ready=0, regf_we=0. Release, then idle all-zero inputs (pd=0) -> no entry allocated.
- Dispatch rs_select=0, ready1=1, ready2=0, ps1=32, ps2=33, rd=2, pd=45, rob=0, cdb=38, fu_busy=0 -> entry stored; fu_ready=0 next cycle.
- Continuing from that state, drive cdb_ps_id=33 -> next cycle fu_ready=1 and regf_we=1. The entry is freed, and the following cycle fu_ready=0.
- Same dispatch but with cdb_ps_id=33 in the dispatch cycle (bypass) -> fu_ready=1 the next cycle.
- Two ready entries with fu_busy=1 for 3 cycles -> fu_ready=1, regf_we=0 throughout. Release fu_busy -> regf_we high for 2 consecutive cycles, lower index first.
- Fill all DEPTH entries with unready ops, then dispatch one more -> it is dropped. Wake everything -> exactly DEPTH regf_we pulses.
